// File: rtl/lcd_pkg.sv
// Shared types and helpers for the HD44780-style LCD bus driver.
// Field positions follow the core's LCD register word.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_EXEC
    } lcd_state_e;

    typedef struct packed {
        logic       on;
        logic       rs;
        logic       rw;
        logic [7:0] data;
    } lcd_word_t;

    localparam int LCD_ON_BIT   = 31;
    localparam int LCD_RS_BIT   = 9;
    localparam int LCD_RW_BIT   = 8;
    localparam int LCD_DATA_MSB = 7;
    localparam int LCD_DATA_LSB = 0;

    // Clear (0x01) and home (0x02/0x03) need the long execution wait
    function automatic logic is_long_cmd(
        input logic       rs,
        input logic [7:0] data
    );
        return !rs && (data[7:2] == 6'd0);
    endfunction

    function automatic lcd_word_t to_word(input logic [31:0] cmd);
        lcd_word_t w;
        w.on   = cmd[LCD_ON_BIT];
        w.rs   = cmd[LCD_RS_BIT];
        w.rw   = cmd[LCD_RW_BIT];
        w.data = cmd[LCD_DATA_MSB:LCD_DATA_LSB];
        return w;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_cnt.sv
// Loadable down-counter with zero flag; holds at zero instead of wrapping.
// Reset value is a parameter so the power-up wait starts out of reset.
module lcd_cnt #(
    parameter int              CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= RST_VAL;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/lcd_driver.sv
// HD44780-style LCD bus driver: times EN around each core write and
// buffers one pending command while the controller is busy.
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int T_PWRUP     = 750000,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_lcd_vld,
    input  logic [31:0] i_lcd_cmd,
    output logic        o_lcd_on,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic [7:0]  o_lcd_data,
    output logic        o_busy,
    output logic        o_pend,
    output logic        o_drop
);

    localparam int T_MAX = max_int(
        max_int(max_int(T_PWRUP, T_SETUP), max_int(T_PULSE, T_HOLD)),
        max_int(T_EXEC, T_EXEC_LONG));
    localparam int CNT_W = $clog2(T_MAX) + 1;

    localparam logic [CNT_W-1:0] LD_PWRUP = CNT_W'(T_PWRUP - 1);
    localparam logic [CNT_W-1:0] LD_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LD_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LD_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LD_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LD_LONG  = CNT_W'(T_EXEC_LONG - 1);

    lcd_state_e       state;
    lcd_state_e       next_state;
    logic             zero;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             launch;
    logic             launch_pend;
    logic             direct;
    logic             store;
    logic             drop;
    logic             pend_vld;
    lcd_word_t        pend_word;
    lcd_word_t        in_word;
    lcd_word_t        launch_word;
    logic             unused_bits;

    assign in_word     = to_word(i_lcd_cmd);
    assign unused_bits = ^i_lcd_cmd[30:10];

    lcd_cnt #(
        .CNT_W   (CNT_W),
        .RST_VAL (LD_PWRUP)
    ) u_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (load),
        .load_val (load_val),
        .zero     (zero)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ST_PWRUP;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        load        = 1'b0;
        load_val    = '0;
        launch      = 1'b0;
        launch_pend = 1'b0;
        unique case (state)
            ST_PWRUP: begin
                if (zero) next_state = ST_IDLE;
            end
            ST_IDLE: begin
                if (pend_vld || i_lcd_vld) begin
                    next_state  = ST_SETUP;
                    load        = 1'b1;
                    load_val    = LD_SETUP;
                    launch      = 1'b1;
                    launch_pend = pend_vld;
                end
            end
            ST_SETUP: begin
                if (zero) begin
                    next_state = ST_PULSE;
                    load       = 1'b1;
                    load_val   = LD_PULSE;
                end
            end
            ST_PULSE: begin
                if (zero) begin
                    next_state = ST_HOLD;
                    load       = 1'b1;
                    load_val   = LD_HOLD;
                end
            end
            ST_HOLD: begin
                if (zero) begin
                    next_state = ST_EXEC;
                    load       = 1'b1;
                    load_val   = is_long_cmd(o_lcd_rs, o_lcd_data)
                               ? LD_LONG : LD_EXEC;
                end
            end
            ST_EXEC: begin
                if (zero) begin
                    if (pend_vld) begin
                        next_state  = ST_SETUP;
                        load        = 1'b1;
                        load_val    = LD_SETUP;
                        launch      = 1'b1;
                        launch_pend = 1'b1;
                    end else begin
                        next_state = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_PWRUP;
        endcase
    end

    // A consumed pending slot can take the new strobe in the same cycle
    assign direct = launch && !launch_pend;
    assign store  = i_lcd_vld && !direct && (!pend_vld || launch_pend);
    assign drop   = i_lcd_vld && !direct && !store;
    assign launch_word = launch_pend ? pend_word : in_word;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pend_vld  <= 1'b0;
            pend_word <= '0;
        end else if (store) begin
            pend_vld  <= 1'b1;
            pend_word <= in_word;
        end else if (launch_pend) begin
            pend_vld  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lcd_on   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_rw   <= 1'b0;
            o_lcd_data <= '0;
            o_lcd_en   <= 1'b0;
            o_drop     <= 1'b0;
        end else begin
            if (launch) begin
                o_lcd_on   <= launch_word.on;
                o_lcd_rs   <= launch_word.rs;
                o_lcd_rw   <= launch_word.rw;
                o_lcd_data <= launch_word.data;
            end
            o_lcd_en <= (next_state == ST_PULSE);
            o_drop   <= drop;
        end
    end

    assign o_busy = (state != ST_IDLE);
    assign o_pend = pend_vld;

endmodule

// File: tb/tb_lcd_driver.sv
// Directed bench for lcd_driver with shortened timing parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_lcd_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vld = 1'b0;
    logic [31:0] cmd = '0;
    logic        on;
    logic        rs;
    logic        rw;
    logic        en;
    logic [7:0]  data;
    logic        busy;
    logic        pend;
    logic        drop;
    logic [11:0] pins;

    int n_checks = 0;
    int n_errors = 0;

    assign pins = {on, rs, rw, en, data};

    always #5 clk = ~clk;

    lcd_driver #(
        .T_PWRUP     (5),
        .T_SETUP     (2),
        .T_PULSE     (3),
        .T_HOLD      (2),
        .T_EXEC      (4),
        .T_EXEC_LONG (10)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_lcd_vld  (vld),
        .i_lcd_cmd  (cmd),
        .o_lcd_on   (on),
        .o_lcd_rs   (rs),
        .o_lcd_rw   (rw),
        .o_lcd_en   (en),
        .o_lcd_data (data),
        .o_busy     (busy),
        .o_pend     (pend),
        .o_drop     (drop)
    );

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic busy_len(output int n);
        n = 0;
        while (busy && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic run_cmd(
        input  logic [31:0] c,
        output logic [11:0] p0,
        output int          nbusy,
        output int          nen,
        output int          en_first
    );
        cmd = c;
        vld = 1'b1;
        step();
        vld = 1'b0;
        p0 = pins;
        nbusy = 0;
        nen = 0;
        en_first = -1;
        while (busy && nbusy < 200) begin
            if (en) begin
                if (en_first < 0) en_first = nbusy;
                nen++;
            end
            nbusy++;
            step();
        end
    endtask

    task automatic wait_data(
        input  logic [7:0] d,
        input  int         start,
        output int         idx
    );
        idx = start;
        while (data !== d && idx < 100) begin
            step();
            idx++;
        end
    endtask

    initial begin
        int          n;
        int          ne;
        int          ef;
        int          idx;
        int          nidle;
        logic [11:0] p0;

        #12;
        check("rst_busy", busy, 1);
        check("rst_pend", pend, 0);
        check("rst_drop", drop, 0);
        check("rst_pins", pins, 0);
        step();
        rst_n = 1'b1;
        busy_len(n);
        check("pwrup_busy", n, 5);
        check("pwrup_pins", pins, 0);

        run_cmd(32'h8000_0241, p0, n, ne, ef);
        check("wr_pins", p0, 12'hC41);
        check("wr_busy", n, 11);
        check("wr_en_len", ne, 3);
        check("wr_en_start", ef, 2);
        check("wr_hold", pins, 12'hC41);

        run_cmd(32'h8000_0001, p0, n, ne, ef);
        check("clr_pins", p0, 12'h801);
        check("clr_busy", n, 17);
        run_cmd(32'h8000_0004, p0, n, ne, ef);
        check("ent_busy", n, 11);
        run_cmd(32'h0000_0102, p0, n, ne, ef);
        check("rd_pins", p0, 12'h202);
        check("rd_busy", n, 17);
        run_cmd(32'h0000_0603, p0, n, ne, ef);
        check("swen_pins", p0, 12'h403);
        check("swen_busy", n, 11);

        cmd = 32'h0000_0241;
        vld = 1'b1;
        step();
        cmd = 32'h0000_0242;
        step();
        check("buf_pend", pend, 1);
        check("buf_nodrop", drop, 0);
        cmd = 32'h0000_0243;
        step();
        check("buf_drop", drop, 1);
        vld = 1'b0;
        step();
        check("buf_drop_end", drop, 0);
        check("buf_pend2", pend, 1);
        wait_data(8'h42, 3, idx);
        check("b2b_idx", idx, 11);
        check("b2b_busy", busy, 1);
        check("b2b_pend", pend, 0);
        busy_len(n);
        check("b2b_len", n, 11);
        check("b2b_last", pins, 12'h442);

        cmd = 32'h8000_0241;
        vld = 1'b1;
        step();
        cmd = 32'h8000_0242;
        step();
        vld = 1'b0;
        repeat (9) step();
        check("sim_busy", busy, 1);
        cmd = 32'h8000_0243;
        vld = 1'b1;
        step();
        vld = 1'b0;
        check("sim_data", data, 8'h42);
        check("sim_nodrop", drop, 0);
        check("sim_pend", pend, 1);
        wait_data(8'h43, 11, idx);
        check("sim_idx", idx, 22);
        busy_len(n);
        check("sim_len", n, 11);
        check("sim_pend_end", pend, 0);

        rst_n = 1'b0;
        #2;
        check("rst2_pins", pins, 0);
        step();
        rst_n = 1'b1;
        cmd = 32'h8000_0233;
        vld = 1'b1;
        step();
        vld = 1'b0;
        check("pw_pend", pend, 1);
        check("pw_busy", busy, 1);
        check("pw_data", data, 0);
        idx = 1;
        nidle = 0;
        while (data !== 8'h33 && idx < 100) begin
            step();
            idx++;
            if (!busy) nidle++;
        end
        check("pw_idx", idx, 6);
        check("pw_idle", nidle, 1);
        busy_len(n);
        check("pw_len", n, 11);

        cmd = 32'h8000_0241;
        vld = 1'b1;
        step();
        cmd = 32'h8000_0242;
        step();
        vld = 1'b0;
        step();
        check("mid_en", en, 1);
        check("mid_pend", pend, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_en_rst", en, 0);
        check("mid_pend_rst", pend, 0);
        check("mid_busy_rst", busy, 1);
        check("mid_pins_rst", pins, 0);
        step();
        rst_n = 1'b1;
        busy_len(n);
        check("mid_pwrup", n, 5);
        repeat (3) step();
        check("mid_no_launch", pins, 0);
        check("mid_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
